bin_to_bcd_seq: RTL and testbench



---
 rtl/bin_to_bcd_seq_if.sv | 24 ++
 rtl/bin_to_bcd_seq.sv | 111 +++++++++++
 tb/tb_bin_to_bcd_seq.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/bin_to_bcd_seq_if.sv
// Handshake and result bus between a binary producer and the serial BCD converter.
interface bin_to_bcd_seq_if #(
    parameter int unsigned BIN_W  = 14,
    parameter int unsigned DIGITS = 4
);
    logic                  start;
    logic [BIN_W-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  ovf;

    // Requester drives start/bin and observes status and result
    modport master (
        output start, bin,
        input  busy, done, bcd, ovf
    );

    // Converter consumes start/bin and produces status and result
    modport slave (
        input  start, bin,
        output busy, done, bcd, ovf
    );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Serial binary-to-BCD converter (double dabble, one bit per clock) with
// start/busy/done handshake. Values above 10^DIGITS-1 saturate to all nines.
module bin_to_bcd_seq #(
    parameter int unsigned BIN_W  = 14,
    parameter int unsigned DIGITS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    bin_to_bcd_seq_if.slave   bus
);
    localparam int unsigned BCD_W   = 4 * DIGITS;
    localparam int unsigned SCR_W   = BCD_W + 1;
    localparam int unsigned CNT_W   = $clog2(BIN_W + 1);
    localparam int unsigned MAX_VAL = 10**DIGITS - 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [SCR_W-1:0]   scr_q, scr_d;
    logic               sat_q, sat_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [SCR_W-1:0]   adj;

    // Next-state, datapath and registered-output values
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        scr_d   = scr_q;
        sat_d   = sat_q;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        adj     = scr_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    bin_d   = bus.bin;
                    scr_d   = '0;
                    cnt_d   = CNT_W'(BIN_W);
                    sat_d   = (32'(bus.bin) > 32'(MAX_VAL));
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // All digits corrected from the pre-shift value, then shift in one bit
                for (int i = 0; i < int'(DIGITS); i++) begin
                    if (scr_q[4*i +: 4] >= 4'd5) begin
                        adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
                    end
                end
                {scr_d, bin_d} = {adj[SCR_W-2:0], bin_q, 1'b0};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                bcd_d   = sat_q ? {DIGITS{4'h9}} : scr_q[BCD_W-1:0];
                ovf_d   = sat_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_SHIFT);
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bin_q   <= '0;
            scr_q   <= '0;
            sat_q   <= 1'b0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            scr_q   <= scr_d;
            sat_q   <= sat_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.bcd  = bcd_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: cycle-level protocol model plus directed literal checks.
module tb_bin_to_bcd_seq;
    localparam int unsigned BIN_W  = 14;
    localparam int unsigned DIGITS = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bin_to_bcd_seq_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

    bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Decimal digits of v by plain division
    function automatic logic [15:0] to_bcd(input int unsigned v);
        logic [15:0] r;
        int unsigned d;
        r = '0;
        d = 1;
        for (int k = 0; k < 4; k++) begin
            r[4*k +: 4] = 4'((v / d) % 10);
            d = d * 10;
        end
        return r;
    endfunction

    // Decimal addition of two packed 4-digit BCD values, carry-out in bit 16
    function automatic logic [16:0] bcd_add(input logic [15:0] x, input logic [15:0] y);
        int unsigned vx, vy, s, d;
        vx = 0; vy = 0; d = 1;
        for (int k = 0; k < 4; k++) begin
            vx = vx + int'(x[4*k +: 4]) * d;
            vy = vy + int'(y[4*k +: 4]) * d;
            d = d * 10;
        end
        s = vx + vy;
        return {(s > 9999) ? 1'b1 : 1'b0, to_bcd(s % 10000)};
    endfunction

    // Protocol model: acceptance edge a, busy after edges a..a+13, done/result after edge a+15
    longint e = 0;
    longint a = 0;
    longint next_free = 0;
    bit active = 0;
    logic m_busy = 0, m_done = 0, m_ovf = 0, p_ovf = 0;
    logic [15:0] m_bcd = '0, p_bcd = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active = 0; next_free = 0;
            m_busy = 0; m_done = 0; m_bcd = '0; m_ovf = 0;
        end else begin
            e++;
            m_done = 0;
            if (active && e == a + 15) begin
                m_done = 1; m_bcd = p_bcd; m_ovf = p_ovf; active = 0;
            end
            if (bus.start === 1'b1 && e >= next_free) begin
                a = e; next_free = e + 16; active = 1;
                p_ovf = (int'(bus.bin) > 9999);
                p_bcd = to_bcd(p_ovf ? 9999 : int'(bus.bin));
            end
            m_busy = active && (e <= a + 13);
        end
    end

    // Per-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        logic nib_ok;
        nib_ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (bus.bcd[4*k +: 4] > 4'd9) nib_ok = 1'b0;
        end
        check("cycle_outputs", {12'd0, bus.busy, bus.done, bus.ovf, 1'b0, bus.bcd},
                               {12'd0, m_busy, m_done, m_ovf, 1'b0, m_bcd});
        check("bcd_digits_valid", {31'd0, nib_ok}, 32'd1);
    end

    task automatic run_conv(input logic [13:0] v, input logic [15:0] exp_bcd,
                            input logic exp_ovf, output logic [15:0] got);
        int k;
        bit seen;
        @(negedge clk); bus.start = 1'b1; bus.bin = v;
        @(negedge clk); bus.start = 1'b0;
        k = 1; seen = 0;
        while (!seen && k < 40) begin
            @(negedge clk); k++;
            if (bus.done === 1'b1) seen = 1;
        end
        check("latency", 32'(k), 32'd16);
        check("bcd_literal", {16'd0, bus.bcd}, {16'd0, exp_bcd});
        check("ovf_literal", {31'd0, bus.ovf}, {31'd0, exp_ovf});
        got = bus.bcd;
    endtask

    initial begin
        logic [15:0] r;
        logic [15:0] r1234, r0500, r0042;
        int dcount, gap, k;
        bit seen;

        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] r, r1234, r0500, r0042;
        int dcount, gap, k;
        bit seen;

        bus.start = 1'b0;
        bus.bin = '0;
        repeat (2) @(negedge clk);
        check("reset_state", {14'd0, bus.busy, bus.done, bus.ovf, bus.bcd}, 32'd0);
        rst_n = 1'b1;

        // Model pins
        check("model_to_bcd", {16'd0, to_bcd(1234)}, 32'h1234);
        check("model_bcd_add", {15'd0, bcd_add(16'h0999, 16'h0001)}, {15'd0, 17'h0_1000});

        run_conv(14'd0,     16'h0000, 1'b0, r);
        run_conv(14'd1234,  16'h1234, 1'b0, r1234);
        run_conv(14'd9999,  16'h9999, 1'b0, r);
        run_conv(14'd9,     16'h0009, 1'b0, r);
        run_conv(14'd10,    16'h0010, 1'b0, r);
        run_conv(14'd10000, 16'h9999, 1'b1, r);
        run_conv(14'd16383, 16'h9999, 1'b1, r);
        run_conv(14'd5,     16'h0005, 1'b0, r);

        // Starts during SHIFT and DONE are dropped
        @(negedge clk); bus.start = 1'b1; bus.bin = 14'd42;
        dcount = 0;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            if (bus.done === 1'b1) dcount++;
            case (n)
                1, 4, 16: bus.start = 1'b0;
                3, 14:    begin bus.start = 1'b1; bus.bin = 14'd7777; end
                default:  ;
            endcase
        end
        check("busy_start_done", {31'd0, bus.done}, 32'd1);
        check("busy_start_bcd", {16'd0, bus.bcd}, 32'h0042);
        r0042 = bus.bcd;
        dcount = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) dcount++;
        end
        check("no_second_conv", 32'(dcount), 32'd0);

        // Asynchronous reset mid-conversion
        @(negedge clk); bus.start = 1'b1; bus.bin = 14'd500;
        @(negedge clk); bus.start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_reset", {14'd0, bus.busy, bus.done, bus.ovf, bus.bcd}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        run_conv(14'd500, 16'h0500, 1'b0, r0500);

        // Back-to-back conversions with start held high
        @(negedge clk); bus.start = 1'b1; bus.bin = 14'd0;
        gap = 0;
        for (int i = 0; i <= 20; i++) begin
            k = 0; seen = 0;
            while (!seen && k < 40) begin
                @(negedge clk); k++;
                if (bus.done === 1'b1) seen = 1;
            end
            if (i > 0) check("done_period", 32'(k), 32'd16);
            else check("first_done", {31'd0, seen}, 32'd1);
            if (i == 20) begin
                bus.start = 1'b0;
                check("stream_last", {16'd0, bus.bcd}, 32'h0020);
            end else begin
                bus.bin = 14'(i + 1);
            end
        end
        repeat (4) @(negedge clk);

        // Results feed the decimal adder stage
        check("adder_sum_a", {15'd0, bcd_add(r1234, r0500)}, {15'd0, 17'h0_1734});
        check("adder_sum_b", {15'd0, bcd_add(16'h9999, r0042)}, {15'd0, 17'h1_0041});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
